mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 1023, max cycles waited for read data after command acceptance (10-bit counter).
REQ-002 clk_sys  in  1  system clock; all logic on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 r0_req  in  1  requester 0 (HPS DMA bridge) request; held high until r0_ack.
REQ-005 r0_we / r0_addr / r0_wdata  in  1/32/32  requester 0 direction (1=write), byte address, write data; stable while r0_req high.
REQ-006 r0_ack  out  1  one-cycle completion pulse to requester 0.
REQ-007 r0_err  out  1  high only together with r0_ack when the read timed out.
REQ-008 r0_rdata  out  32  read data for requester 0.
REQ-009 r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata: same widths and meaning for requester 1 (secondary disk/debug port).
REQ-010 avm_address / avm_writedata  out  32/32  Avalon master address and write data.
REQ-011 avm_read / avm_write  out  1/1  Avalon command strobes.
REQ-012 avm_byteenable  out  4  constant 4'b1111.
REQ-013 avm_waitrequest / avm_readdatavalid  in  1/1  Avalon flow control.
REQ-014 avm_readdata  in  32  Avalon read data.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 States SHALL be IDLE, ISSUE, WAITDATA, DONE; one transaction outstanding at a time.
REQ-017 IDLE: if any req high, grant per round-robin, latch we/addr/wdata and grant id, go ISSUE next cycle; else stay.
REQ-018 Round-robin: on simultaneous requests the requester not granted last wins; single request is granted regardless of pointer.
REQ-019 Grant pointer SHALL update in DONE to the requester just served.
REQ-020 ISSUE: assert avm_read (we=0) or avm_write (we=1) with latched address/data; hold all command outputs stable while avm_waitrequest=1.
REQ-021 ISSUE with avm_waitrequest=0: command accepted that cycle; write -> DONE, read -> WAITDATA; strobes deassert next cycle.
REQ-022 No timeout SHALL apply in ISSUE (Avalon commands cannot be aborted).
REQ-023 WAITDATA: counter starts at 0 on entry, increments each cycle; on avm_readdatavalid capture avm_readdata into granted rdata, go DONE.
REQ-024 WAITDATA: if counter reaches TIMEOUT_CYC without readdatavalid, load granted rdata with 32'hFFFFFFFF, set error flag, go DONE.
REQ-025 readdatavalid in IDLE, ISSUE or DONE (including late data after timeout) SHALL be ignored and SHALL NOT alter any rdata.
REQ-026 DONE: pulse granted ack (and err if flagged) for exactly one cycle, clear error flag, go IDLE.
REQ-027 Request levels SHALL be ignored in DONE; requester deasserts req the cycle after ack, so a new request is sampled no earlier than IDLE.
REQ-028 Latency (zero wait): req seen in IDLE cycle k -> strobe cycle k+1 -> write ack cycle k+2; read ack one cycle after readdatavalid.
REQ-029 rdata of each requester SHALL hold until that requester's next read completion; writes do not modify rdata.
REQ-030 Non-granted requester's ack/err SHALL stay 0 throughout.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, all ack/err=0, both rdata=0, busy=0, counter=0, grant pointer = requester 1 (so requester 0 wins the first tie).
REQ-032 Reset mid-transaction SHALL abandon it without ack; first transaction after release starts from IDLE.

Verification
REQ-033 Write r0: addr 0x100, wdata 0xDEADBEEF, waitrequest=0 -> avm_write with 0x100/0xDEADBEEF one cycle, r0_ack 2 cycles after req, r0_rdata unchanged.
REQ-034 Read r1: addr 0x200, waitrequest high 3 cycles, readdatavalid 4 cycles later with 0x12345678 -> avm_read held stable 4 cycles, r1_ack with r1_rdata=0x12345678, r1_err=0.
REQ-035 Both req high from reset, back-to-back reads -> service order r0, r1, r0, r1; never two acks same cycle.
REQ-036 Read with no readdatavalid, TIMEOUT_CYC=1023 -> r0_ack and r0_err together, r0_rdata=0xFFFFFFFF; late readdatavalid 0x55 afterwards ignored.
REQ-037 reset_n low during WAITDATA -> busy=0, strobes 0, no ack; next read completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter onto a single Avalon-MM master port.
// One transaction is in flight at a time. Reads time out to 32'hFFFFFFFF with an error flag.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [31:0] r1_rdata,
    output logic [31:0] avm_address,
    output logic [31:0] avm_writedata,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAITDATA, DONE} state_t;

    state_t        state, state_nx;
    logic          gnt, gnt_nx;
    logic          ptr, ptr_nx;
    logic          we_q, we_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          rd_nx, wr_nx;
    logic [DW-1:0] addr_nx, wdata_nx;
    logic          ack0_nx, ack1_nx, err0_nx, err1_nx;
    logic [DW-1:0] rdata0_nx, rdata1_nx;
    logic          busy_nx;
    logic          sel, fin, fin_err, load;
    logic [DW-1:0] load_val;

    assign avm_byteenable = 4'b1111;

    // State and registered outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            gnt           <= 1'b0;
            ptr           <= 1'b1;
            we_q          <= 1'b0;
            cnt           <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            r0_ack        <= 1'b0;
            r1_ack        <= 1'b0;
            r0_err        <= 1'b0;
            r1_err        <= 1'b0;
            r0_rdata      <= '0;
            r1_rdata      <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            gnt           <= gnt_nx;
            ptr           <= ptr_nx;
            we_q          <= we_nx;
            cnt           <= cnt_nx;
            avm_read      <= rd_nx;
            avm_write     <= wr_nx;
            avm_address   <= addr_nx;
            avm_writedata <= wdata_nx;
            r0_ack        <= ack0_nx;
            r1_ack        <= ack1_nx;
            r0_err        <= err0_nx;
            r1_err        <= err1_nx;
            r0_rdata      <= rdata0_nx;
            r1_rdata      <= rdata1_nx;
            busy          <= busy_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        ptr_nx    = ptr;
        we_nx     = we_q;
        cnt_nx    = cnt;
        rd_nx     = avm_read;
        wr_nx     = avm_write;
        addr_nx   = avm_address;
        wdata_nx  = avm_writedata;
        rdata0_nx = r0_rdata;
        rdata1_nx = r1_rdata;
        sel       = 1'b0;
        fin       = 1'b0;
        fin_err   = 1'b0;
        load      = 1'b0;
        load_val  = '0;

        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    // On a tie the requester not served last wins
                    sel      = (r0_req && r1_req) ? ~ptr : r1_req;
                    gnt_nx   = sel;
                    we_nx    = sel ? r1_we    : r0_we;
                    addr_nx  = sel ? r1_addr  : r0_addr;
                    wdata_nx = sel ? r1_wdata : r0_wdata;
                    rd_nx    = ~we_nx;
                    wr_nx    = we_nx;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest) begin
                    rd_nx  = 1'b0;
                    wr_nx  = 1'b0;
                    cnt_nx = '0;
                    if (we_q) begin
                        fin      = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = WAITDATA;
                    end
                end
            end
            WAITDATA: begin
                if (avm_readdatavalid) begin
                    load     = 1'b1;
                    load_val = avm_readdata;
                    fin      = 1'b1;
                    state_nx = DONE;
                end else if (cnt == CW'(TIMEOUT_CYC)) begin
                    load     = 1'b1;
                    load_val = '1;
                    fin      = 1'b1;
                    fin_err  = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DONE: begin
                ptr_nx   = gnt;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (load) begin
            if (gnt) rdata1_nx = load_val;
            else     rdata0_nx = load_val;
        end

        ack0_nx = fin & ~gnt;
        ack1_nx = fin & gnt;
        err0_nx = fin_err & ~gnt;
        err1_nx = fin_err & gnt;
        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked against a round-robin / per-requester read-data model.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 1023;

    logic        clk_sys;
    logic        reset_n;
    logic        r0_req, r0_we, r0_ack, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_ack, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic [3:0]  avm_byteenable;
    logic        busy;

    int          vectors;
    int          miscompares;

    bit          p_req   [2];
    bit          p_we    [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [31:0] m_rdata [2];
    int          last;

    mem_port_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_read(avm_read), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata), .busy(busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int w);
        return (w == 1) ? r1_ack : r0_ack;
    endfunction

    task automatic drive_reqs();
        r0_req = p_req[0]; r0_we = p_we[0]; r0_addr = p_addr[0]; r0_wdata = p_wdata[0];
        r1_req = p_req[1]; r1_we = p_we[1]; r1_addr = p_addr[1]; r1_wdata = p_wdata[1];
    endtask

    task automatic model_reset();
        last = 1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        p_req[0] = 1'b0; p_req[1] = 1'b0;
    endtask

    task automatic new_req(input int j, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        p_req[j] = 1'b1; p_we[j] = we; p_addr[j] = addr; p_wdata[j] = wdata;
    endtask

    task automatic chk_rdata();
        chk32("r0_rdata", r0_rdata, m_rdata[0]);
        chk32("r1_rdata", r1_rdata, m_rdata[1]);
    endtask

    task automatic check_reset_state();
        chk1("rst_avm_read", avm_read, 1'b0);
        chk1("rst_avm_write", avm_write, 1'b0);
        chk32("rst_avm_address", avm_address, 32'h0);
        chk32("rst_avm_writedata", avm_writedata, 32'h0);
        chk32("rst_byteenable", 32'(avm_byteenable), 32'hF);
        chk32("rst_acks", 32'({r1_ack, r0_ack}), 32'h0);
        chk32("rst_errs", 32'({r1_err, r0_err}), 32'h0);
        chk32("rst_r0_rdata", r0_rdata, 32'h0);
        chk32("rst_r1_rdata", r1_rdata, 32'h0);
        chk1("rst_busy", busy, 1'b0);
    endtask

    // Run one arbitration + bus transaction from IDLE back to IDLE; requests already driven
    task automatic serve(input int ws, input int lat, input logic [31:0] rdat,
                         input bit no_data, output int served);
        int w;
        int n;
        bit exp_err;
        logic [31:0] ea, ed;
        w = (p_req[0] && p_req[1]) ? 1 - last : (p_req[0] ? 0 : 1);
        ea = p_addr[w];
        ed = p_wdata[w];
        exp_err = 1'b0;
        tick();
        chk1("busy_issue", busy, 1'b1);
        chk1("avm_read", avm_read, !p_we[w]);
        chk1("avm_write", avm_write, p_we[w]);
        chk32("avm_address", avm_address, ea);
        if (p_we[w]) chk32("avm_writedata", avm_writedata, ed);
        for (int i = 0; i < ws; i++) begin
            avm_waitrequest   = 1'b1;
            avm_readdatavalid = 1'($urandom_range(0, 1));
            avm_readdata      = $urandom;
            tick();
            chk1("hold_read", avm_read, !p_we[w]);
            chk1("hold_write", avm_write, p_we[w]);
            chk32("hold_address", avm_address, ea);
            if (p_we[w]) chk32("hold_writedata", avm_writedata, ed);
            chk1("no_ack_issue", r0_ack | r1_ack, 1'b0);
        end
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        tick();
        chk1("strobe_off", avm_read | avm_write, 1'b0);
        if (!p_we[w]) begin
            if (!no_data) begin
                for (int i = 0; i < lat; i++) begin
                    chk1("no_early_ack", r0_ack | r1_ack, 1'b0);
                    tick();
                end
                avm_readdatavalid = 1'b1;
                avm_readdata      = rdat;
                tick();
                avm_readdatavalid = 1'b0;
                m_rdata[w] = rdat;
            end else begin
                n = 0;
                while (ack_of(w) == 1'b0 && n < int'(TO) + 50) begin
                    tick();
                    n++;
                end
                chk1("timeout_window", (n >= int'(TO)) && (n <= int'(TO) + 2), 1'b1);
                m_rdata[w] = 32'hFFFF_FFFF;
                exp_err = 1'b1;
            end
        end
        served = r1_ack ? 1 : (r0_ack ? 0 : -1);
        chk32("ack_vec", 32'({r1_ack, r0_ack}), 32'((w == 1) ? 2 : 1));
        chk32("err_vec", 32'({r1_err, r0_err}), exp_err ? 32'((w == 1) ? 2 : 1) : 32'h0);
        chk_rdata();
        last = w;
        p_req[w] = 1'b0;
        drive_reqs();
        avm_readdatavalid = 1'($urandom_range(0, 1));
        avm_readdata      = $urandom;
        tick();
        avm_readdatavalid = 1'b0;
        chk32("ack_vec_after", 32'({r1_ack, r0_ack}), 32'h0);
        chk32("err_vec_after", 32'({r1_err, r0_err}), 32'h0);
        chk1("busy_idle", busy, 1'b0);
        chk_rdata();
    endtask

    initial begin
        int s;
        vectors = 0;
        miscompares = 0;
        p_we[0] = 1'b0; p_we[1] = 1'b0;
        p_addr[0] = '0; p_addr[1] = '0;
        p_wdata[0] = '0; p_wdata[1] = '0;
        model_reset();
        drive_reqs();
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        reset_n = 1'b0;
        tick();
        tick();
        check_reset_state();
        reset_n = 1'b1;
        tick();

        // Zero-wait write from requester 0
        new_req(0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        drive_reqs();
        serve(0, 0, 32'h0, 1'b0, s);
        chk32("w0_served", 32'(s), 32'h0);

        // Read from requester 1 with three wait-request cycles
        new_req(1, 1'b0, 32'h200, 32'h0);
        drive_reqs();
        serve(3, 3, 32'h1234_5678, 1'b0, s);
        chk32("r1_served", 32'(s), 32'h1);

        // Both requesting from reset: strict alternation starting at requester 0
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        tick();
        check_reset_state();
        new_req(0, 1'b0, 32'h400, 32'h0);
        new_req(1, 1'b0, 32'h500, 32'h0);
        for (int i = 0; i < 4; i++) begin
            p_req[0] = 1'b1;
            p_req[1] = 1'b1;
            drive_reqs();
            serve($urandom_range(0, 2), $urandom_range(0, 3), $urandom, 1'b0, s);
            chk32("rr_order", 32'(s), 32'(i % 2));
        end
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        drive_reqs();
        tick();

        // Read timeout, then late data must be ignored
        new_req(0, 1'b0, 32'h600, 32'h0);
        drive_reqs();
        serve(0, 0, 32'h0, 1'b1, s);
        chk32("to_served", 32'(s), 32'h0);
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h55;
        tick();
        avm_readdatavalid = 1'b0;
        chk32("late_data_r0_rdata", r0_rdata, 32'hFFFF_FFFF);
        chk32("late_data_acks", 32'({r1_ack, r0_ack}), 32'h0);
        tick();

        // Reset while waiting for read data
        new_req(1, 1'b0, 32'h300, 32'h0);
        drive_reqs();
        tick();
        chk1("mid_read_strobe", avm_read, 1'b1);
        tick();
        tick();
        tick();
        chk1("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        drive_reqs();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_reset_state();
        new_req(1, 1'b0, 32'h304, 32'h0);
        drive_reqs();
        serve(1, 2, 32'hCAFE_F00D, 1'b0, s);
        chk32("post_reset_served", 32'(s), 32'h1);

        // Random traffic; a pending loser keeps its request stable
        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < 2; j++)
                if (!p_req[j] && $urandom_range(0, 1) == 1)
                    new_req(j, 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!p_req[0] && !p_req[1])
                new_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom);
            drive_reqs();
            serve($urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'b0, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
